// File: rtl/ctrl_pkg.sv
// Opcode map, ALU operation codes and the control bundle for the decode pipeline.
// Optional macro CTRL_ILLEGAL_OP_EN adds an illegal_op flag to the bundle.
package ctrl_pkg;

  localparam int unsigned OPC_BITS = 6;
  localparam int unsigned ALU_BITS = 4;

  localparam logic [OPC_BITS-1:0] OPC_SLL     = 6'b000001;
  localparam logic [OPC_BITS-1:0] OPC_SRL     = 6'b000010;
  localparam logic [OPC_BITS-1:0] OPC_ADD     = 6'b000101;
  localparam logic [OPC_BITS-1:0] OPC_SUB     = 6'b000110;
  localparam logic [OPC_BITS-1:0] OPC_AND     = 6'b000111;
  localparam logic [OPC_BITS-1:0] OPC_OR      = 6'b001000;
  localparam logic [OPC_BITS-1:0] OPC_XOR     = 6'b001001;
  localparam logic [OPC_BITS-1:0] OPC_NOR     = 6'b001010;
  localparam logic [OPC_BITS-1:0] OPC_SLT     = 6'b001011;
  localparam logic [OPC_BITS-1:0] OPC_JR      = 6'b001100;
  localparam logic [OPC_BITS-1:0] OPC_ADDI    = 6'b010001;
  localparam logic [OPC_BITS-1:0] OPC_SUBI    = 6'b010011;
  localparam logic [OPC_BITS-1:0] OPC_ANDI    = 6'b010100;
  localparam logic [OPC_BITS-1:0] OPC_ORI     = 6'b010101;
  localparam logic [OPC_BITS-1:0] OPC_LUI     = 6'b010110;
  localparam logic [OPC_BITS-1:0] OPC_GETROW  = 6'b011000;
  localparam logic [OPC_BITS-1:0] OPC_MOVL    = 6'b011001;
  localparam logic [OPC_BITS-1:0] OPC_MOVU    = 6'b011010;
  localparam logic [OPC_BITS-1:0] OPC_MOVR    = 6'b011011;
  localparam logic [OPC_BITS-1:0] OPC_MOVD    = 6'b011100;
  localparam logic [OPC_BITS-1:0] OPC_WRSHAPE = 6'b011101;
  localparam logic [OPC_BITS-1:0] OPC_SENDROW = 6'b011110;
  localparam logic [OPC_BITS-1:0] OPC_BEQ     = 6'b100001;
  localparam logic [OPC_BITS-1:0] OPC_BNE     = 6'b100010;
  localparam logic [OPC_BITS-1:0] OPC_J       = 6'b110001;
  localparam logic [OPC_BITS-1:0] OPC_JAL     = 6'b110010;

  typedef enum logic [ALU_BITS-1:0] {
    ALU_SLL     = 4'd0,
    ALU_SRL     = 4'd1,
    ALU_ADD     = 4'd2,
    ALU_SUB     = 4'd3,
    ALU_AND     = 4'd4,
    ALU_OR      = 4'd5,
    ALU_XOR     = 4'd6,
    ALU_NOR     = 4'd7,
    ALU_SLT     = 4'd8,
    ALU_MOVL    = 4'd9,
    ALU_MOVR    = 4'd10,
    ALU_MOVU    = 4'd11,
    ALU_MOVD    = 4'd12,
    ALU_WRSHAPE = 4'd13,
    ALU_LUI     = 4'd14,
    ALU_NONE    = 4'd15
  } alu_op_e;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_WAIT_MEM = 1'b1
  } fsm_state_e;

  // alu_op stays the last field so the bubble constant is independent of optional fields.
  typedef struct packed {
    logic    is_j;
    logic    is_i;
    logic    is_br;
    logic    is_r;
    logic    is_special;
    logic    is_return;
    logic    is_shift;
    logic    if_send_row;
    logic    if_get_row;
    logic    is_move_or_write_shape;
    logic    reg_write;
    logic    is_jal;
`ifdef CTRL_ILLEGAL_OP_EN
    logic    illegal_op;
`endif
    alu_op_e alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE =
    ctrl_t'({{($bits(ctrl_t) - ALU_BITS){1'b0}}, {ALU_BITS{1'b1}}});

endpackage

// File: rtl/ctrl_decode_pipe_if.sv
// Fetch-side, execute-side and memory-completion signals of the decode pipeline.
// Optional macro CTRL_ILLEGAL_OP_EN adds the illegal_op output.
interface ctrl_decode_pipe_if #(
  parameter int unsigned INSTR_W  = 32,
  parameter int unsigned ALU_OP_W = 4
);
  logic                flush;
  logic                in_valid;
  logic [INSTR_W-1:0]  in_instr;
  logic                in_ready;
  logic                out_valid;
  logic                out_ready;
  logic [INSTR_W-1:0]  out_instr;
  logic [ALU_OP_W-1:0] alu_op;
  logic                is_j;
  logic                is_i;
  logic                is_br;
  logic                is_r;
  logic                is_special;
  logic                is_return;
  logic                is_shift;
  logic                if_send_row;
  logic                if_get_row;
  logic                is_move_or_write_shape;
  logic                reg_write;
  logic                is_jal;
  logic                mem_done;
  logic                busy_mem;
`ifdef CTRL_ILLEGAL_OP_EN
  logic                illegal_op;
`endif

  modport master (
    output flush, in_valid, in_instr, out_ready, mem_done,
    input  in_ready, out_valid, out_instr, alu_op, is_j, is_i, is_br, is_r,
           is_special, is_return, is_shift, if_send_row, if_get_row,
           is_move_or_write_shape, reg_write, is_jal, busy_mem
`ifdef CTRL_ILLEGAL_OP_EN
    , input illegal_op
`endif
  );

  modport slave (
    input  flush, in_valid, in_instr, out_ready, mem_done,
    output in_ready, out_valid, out_instr, alu_op, is_j, is_i, is_br, is_r,
           is_special, is_return, is_shift, if_send_row, if_get_row,
           is_move_or_write_shape, reg_write, is_jal, busy_mem
`ifdef CTRL_ILLEGAL_OP_EN
    , output illegal_op
`endif
  );
endinterface

// File: rtl/ctrl_dec_comb.sv
// Purely combinational opcode to control-bundle decoder.
// Optional macro CTRL_ILLEGAL_OP_EN flags undefined opcodes instead of treating them as R-type.
module ctrl_dec_comb
  import ctrl_pkg::*;
(
  input  logic [OPC_BITS-1:0] opcode,
  output ctrl_t               ctrl_c
);

  logic legal;

  always_comb begin
    ctrl_c = CTRL_BUBBLE;
    legal  = 1'b1;
    case (opcode)
      OPC_SLL:  begin ctrl_c.is_shift = 1'b1; ctrl_c.reg_write = 1'b1; ctrl_c.alu_op = ALU_SLL; end
      OPC_SRL:  begin ctrl_c.is_shift = 1'b1; ctrl_c.reg_write = 1'b1; ctrl_c.alu_op = ALU_SRL; end
      OPC_ADD:  begin ctrl_c.reg_write = 1'b1; ctrl_c.alu_op = ALU_ADD; end
      OPC_SUB:  begin ctrl_c.reg_write = 1'b1; ctrl_c.alu_op = ALU_SUB; end
      OPC_AND:  begin ctrl_c.reg_write = 1'b1; ctrl_c.alu_op = ALU_AND; end
      OPC_OR:   begin ctrl_c.reg_write = 1'b1; ctrl_c.alu_op = ALU_OR;  end
      OPC_XOR:  begin ctrl_c.reg_write = 1'b1; ctrl_c.alu_op = ALU_XOR; end
      OPC_NOR:  begin ctrl_c.reg_write = 1'b1; ctrl_c.alu_op = ALU_NOR; end
      OPC_SLT:  begin ctrl_c.reg_write = 1'b1; ctrl_c.alu_op = ALU_SLT; end
      OPC_JR:   ctrl_c.is_return = 1'b1;
      OPC_ADDI: begin ctrl_c.is_i = 1'b1; ctrl_c.reg_write = 1'b1; ctrl_c.alu_op = ALU_ADD; end
      OPC_SUBI: begin ctrl_c.is_i = 1'b1; ctrl_c.reg_write = 1'b1; ctrl_c.alu_op = ALU_SUB; end
      OPC_ANDI: begin ctrl_c.is_i = 1'b1; ctrl_c.reg_write = 1'b1; ctrl_c.alu_op = ALU_AND; end
      OPC_ORI:  begin ctrl_c.is_i = 1'b1; ctrl_c.reg_write = 1'b1; ctrl_c.alu_op = ALU_OR;  end
      OPC_LUI:  begin ctrl_c.is_i = 1'b1; ctrl_c.reg_write = 1'b1; ctrl_c.alu_op = ALU_LUI; end
      OPC_GETROW: begin
        ctrl_c.is_special = 1'b1; ctrl_c.if_get_row = 1'b1; ctrl_c.reg_write = 1'b1;
      end
      OPC_SENDROW: begin ctrl_c.is_special = 1'b1; ctrl_c.if_send_row = 1'b1; end
      OPC_MOVL, OPC_MOVU, OPC_MOVR, OPC_MOVD, OPC_WRSHAPE: begin
        ctrl_c.is_special             = 1'b1;
        ctrl_c.is_move_or_write_shape = 1'b1;
        case (opcode)
          OPC_MOVL: ctrl_c.alu_op = ALU_MOVL;
          OPC_MOVU: ctrl_c.alu_op = ALU_MOVU;
          OPC_MOVR: ctrl_c.alu_op = ALU_MOVR;
          OPC_MOVD: ctrl_c.alu_op = ALU_MOVD;
          default:  ctrl_c.alu_op = ALU_WRSHAPE;
        endcase
      end
      OPC_BEQ, OPC_BNE: begin ctrl_c.is_br = 1'b1; ctrl_c.alu_op = ALU_SUB; end
      OPC_J:    ctrl_c.is_j = 1'b1;
      OPC_JAL:  begin ctrl_c.is_j = 1'b1; ctrl_c.is_jal = 1'b1; ctrl_c.reg_write = 1'b1; end
      default:  legal = 1'b0;
    endcase

    // Undefined opcodes keep alu_op=NONE and reg_write=0 from the bubble default.
    if (legal) begin
      ctrl_c.is_r = !(ctrl_c.is_j || ctrl_c.is_i || ctrl_c.is_br);
    end else begin
`ifdef CTRL_ILLEGAL_OP_EN
      ctrl_c.illegal_op = 1'b1;
`else
      ctrl_c.is_r = 1'b1;
`endif
    end
  end

endmodule

// File: rtl/ctrl_decode_pipe.sv
// Instruction queue, memory-stall FSM and registered control bundle between fetch and execute.
// Optional macro CTRL_ILLEGAL_OP_EN drives the registered illegal_op output.
module ctrl_decode_pipe
  import ctrl_pkg::*;
#(
  parameter int unsigned INSTR_W  = 32,
  parameter int unsigned OPC_W    = 6,
  parameter int unsigned ALU_OP_W = 4,
  parameter int unsigned DEPTH    = 4
) (
  input logic              clk,
  input logic              rst_n,
  ctrl_decode_pipe_if.slave bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fsm_state_e         state_q, state_d;
  logic [INSTR_W-1:0] fifo [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [INSTR_W-1:0] head;
  logic [OPC_BITS-1:0] head_opc;
  ctrl_t              dec_ctrl;
  ctrl_t              ctrl_q;
  logic               out_valid_q;
  logic [INSTR_W-1:0] out_instr_q;
  logic               push;
  logic               load;
  logic               special_taken;

  assign head     = fifo[rd_ptr];
  assign head_opc = OPC_BITS'(head[INSTR_W-1 -: OPC_W]);

  ctrl_dec_comb u_dec (
    .opcode (head_opc),
    .ctrl_c (dec_ctrl)
  );

  // A special leaving the output stage blocks the load behind it so WAIT_MEM starts clean.
  assign bus.in_ready = (count < CNT_W'(DEPTH));
  assign push          = bus.in_valid && bus.in_ready && !bus.flush;
  assign special_taken = out_valid_q && bus.out_ready && ctrl_q.is_special;
  assign load          = (state_q == ST_RUN) && (count != '0) &&
                         (!out_valid_q || bus.out_ready) && !special_taken && !bus.flush;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:      if (special_taken) state_d = ST_WAIT_MEM;
      ST_WAIT_MEM: if (bus.mem_done)  state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase
    if (bus.flush) state_d = ST_RUN;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (load) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(load);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= bus.in_instr;
  end

  // Output stage: load on pop, otherwise fall back to a bubble once the bundle is taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= CTRL_BUBBLE;
      out_instr_q <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= CTRL_BUBBLE;
    end else if (load) begin
      out_valid_q <= 1'b1;
      ctrl_q      <= dec_ctrl;
      out_instr_q <= head;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= CTRL_BUBBLE;
    end
  end

  assign bus.out_valid              = out_valid_q;
  assign bus.out_instr              = out_instr_q;
  assign bus.alu_op                 = ALU_OP_W'(ctrl_q.alu_op);
  assign bus.is_j                   = ctrl_q.is_j;
  assign bus.is_i                   = ctrl_q.is_i;
  assign bus.is_br                  = ctrl_q.is_br;
  assign bus.is_r                   = ctrl_q.is_r;
  assign bus.is_special             = ctrl_q.is_special;
  assign bus.is_return              = ctrl_q.is_return;
  assign bus.is_shift               = ctrl_q.is_shift;
  assign bus.if_send_row            = ctrl_q.if_send_row;
  assign bus.if_get_row             = ctrl_q.if_get_row;
  assign bus.is_move_or_write_shape = ctrl_q.is_move_or_write_shape;
  assign bus.reg_write              = ctrl_q.reg_write;
  assign bus.is_jal                 = ctrl_q.is_jal;
  assign bus.busy_mem               = (state_q == ST_WAIT_MEM);
`ifdef CTRL_ILLEGAL_OP_EN
  assign bus.illegal_op             = ctrl_q.illegal_op;
`endif

endmodule
